// File: rtl/puck_motion_pkg.sv
// Shared game package: screen and paddle geometry, puck/score constants,
// the game state encoding and small helpers. The renderer imports the same
// package so geometry never drifts between motion and drawing.
package puck_motion_pkg;

    localparam int GAME_SCR_W       = 640;
    localparam int GAME_SCR_H       = 480;
    localparam int GAME_PUCK_SZ     = 8;
    localparam int GAME_PAD_H       = 64;
    localparam int GAME_PAD_W       = 8;
    localparam int GAME_PAD_XL      = 16;
    localparam int GAME_PAD_XR      = 616;
    localparam int GAME_SPEED       = 2;
    localparam int GAME_WIN_SCORE   = 7;
    localparam int GAME_HOLD_FRAMES = 60;

    // 12-bit signed working coordinates: wide enough that a step past the
    // left/top edge goes negative instead of wrapping.
    localparam int COORD_W = 12;
    typedef logic signed [COORD_W-1:0] coord_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_HOLD = 2'd2,
        ST_OVER = 2'd3
    } game_state_e;

    // Score increment that sticks at the winning value.
    function automatic logic [3:0] sat_inc(input logic [3:0] s, input logic [3:0] lim);
        sat_inc = (s >= lim) ? lim : s + 4'd1;
    endfunction

endpackage

// File: rtl/puck_motion_paddle_hit.sv
// paddle_hit: combinational overlap test between the puck's candidate
// position and one paddle.
//   puck_x_i, puck_y_i : puck top-left (x is the next-frame x, y the current y)
//   pad_x_i, pad_y_i   : paddle left edge and top edge
//   hit_o              : puck overlaps (or touches the inner face of) the paddle
// RIGHT selects which paddle face counts as touching: the left paddle's
// right face or the right paddle's left face.
module paddle_hit
    import puck_motion_pkg::*;
#(
    parameter int PUCK_SZ = GAME_PUCK_SZ,
    parameter int PAD_W   = GAME_PAD_W,
    parameter int PAD_H   = GAME_PAD_H,
    parameter bit RIGHT   = 1'b0
) (
    input  coord_t puck_x_i,
    input  coord_t puck_y_i,
    input  coord_t pad_x_i,
    input  coord_t pad_y_i,
    output logic   hit_o
);

    localparam coord_t SZ = coord_t'(PUCK_SZ);
    localparam coord_t PW = coord_t'(PAD_W);
    localparam coord_t PH = coord_t'(PAD_H);

    logic x_ov;
    logic y_ov;

    always_comb begin
        if (RIGHT) begin
            x_ov = (puck_x_i + SZ >= pad_x_i) && (puck_x_i < pad_x_i + PW);
        end else begin
            x_ov = (puck_x_i <= pad_x_i + PW) && (puck_x_i + SZ > pad_x_i);
        end
        y_ov  = (puck_y_i + SZ > pad_y_i) && (puck_y_i < pad_y_i + PH);
        hit_o = x_ov && y_ov;
    end

endmodule

// File: rtl/puck_motion.sv
// puck_motion: per-frame puck movement, wall/paddle reflection, scoring
// and serve/hold/game-over sequencing for a two-paddle game.
//   clk, rst_n          : pixel clock, asynchronous active-low reset
//   frame_tick          : one pulse per frame; all motion/score updates use it
//   serve               : one-cycle serve button pulse
//   pad_l_y, pad_r_y    : paddle top y, only looked at on frame_tick
//   puck_x, puck_y      : registered puck top-left
//   score_l, score_r    : registered scores, saturating at WIN_SCORE
//   goal                : one-cycle pulse, high together with the new score
//   state               : game state (IDLE/MOVE/HOLD/OVER), also for debug
module puck_motion
    import puck_motion_pkg::*;
#(
    parameter int SCR_W       = GAME_SCR_W,
    parameter int SCR_H       = GAME_SCR_H,
    parameter int PUCK_SZ     = GAME_PUCK_SZ,
    parameter int PAD_H       = GAME_PAD_H,
    parameter int PAD_W       = GAME_PAD_W,
    parameter int PAD_XL      = GAME_PAD_XL,
    parameter int PAD_XR      = GAME_PAD_XR,
    parameter int SPEED       = GAME_SPEED,
    parameter int WIN_SCORE   = GAME_WIN_SCORE,
    parameter int HOLD_FRAMES = GAME_HOLD_FRAMES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       serve,
    input  logic [9:0] pad_l_y,
    input  logic [9:0] pad_r_y,
    output logic [9:0] puck_x,
    output logic [9:0] puck_y,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic       goal,
    output logic [1:0] state
);

    localparam coord_t         SPD       = coord_t'(SPEED);
    localparam coord_t         MAX_X     = coord_t'(SCR_W - PUCK_SZ);
    localparam coord_t         MAX_Y     = coord_t'(SCR_H - PUCK_SZ);
    localparam logic [9:0]     MAX_X_P   = 10'(SCR_W - PUCK_SZ);
    localparam logic [9:0]     MAX_Y_P   = 10'(SCR_H - PUCK_SZ);
    localparam logic [9:0]     CENTRE_X  = 10'((SCR_W - PUCK_SZ) / 2);
    localparam logic [9:0]     CENTRE_Y  = 10'((SCR_H - PUCK_SZ) / 2);
    localparam logic [9:0]     L_REST_X  = 10'(PAD_XL + PAD_W);
    localparam logic [9:0]     R_REST_X  = 10'(PAD_XR - PUCK_SZ);
    localparam coord_t         PAD_XL_C  = coord_t'(PAD_XL);
    localparam coord_t         PAD_XR_C  = coord_t'(PAD_XR);
    localparam logic [3:0]     WIN       = 4'(WIN_SCORE);
    localparam int             HOLD_W    = $clog2(HOLD_FRAMES + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    game_state_e       state_q, state_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic              vx_pos_q, vx_pos_d, vy_pos_q, vy_pos_d;
    logic [3:0]        score_l_q, score_l_d, score_r_q, score_r_d;
    logic              goal_q, goal_d;
    logic [HOLD_W-1:0] hold_q, hold_d;

    coord_t cur_x, cur_y, vx, vy, nx, ny, pad_l_ext, pad_r_ext;
    logic   hit_l, hit_r, left_hit, right_hit;

    assign cur_x     = $signed({2'b00, x_q});
    assign cur_y     = $signed({2'b00, y_q});
    assign vx        = vx_pos_q ? SPD : -SPD;
    assign vy        = vy_pos_q ? SPD : -SPD;
    assign nx        = cur_x + vx;
    assign ny        = cur_y + vy;
    assign pad_l_ext = $signed({2'b00, pad_l_y});
    assign pad_r_ext = $signed({2'b00, pad_r_y});

    // Horizontal test uses the next x; vertical overlap uses the current y.
    paddle_hit #(.PUCK_SZ(PUCK_SZ), .PAD_W(PAD_W), .PAD_H(PAD_H), .RIGHT(1'b0)) u_hit_l (
        .puck_x_i(nx), .puck_y_i(cur_y), .pad_x_i(PAD_XL_C), .pad_y_i(pad_l_ext), .hit_o(hit_l)
    );
    paddle_hit #(.PUCK_SZ(PUCK_SZ), .PAD_W(PAD_W), .PAD_H(PAD_H), .RIGHT(1'b1)) u_hit_r (
        .puck_x_i(nx), .puck_y_i(cur_y), .pad_x_i(PAD_XR_C), .pad_y_i(pad_r_ext), .hit_o(hit_r)
    );

    // A paddle only reflects a puck travelling towards it.
    assign left_hit  = hit_l && !vx_pos_q;
    assign right_hit = hit_r && vx_pos_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // Datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q       <= CENTRE_X;
            y_q       <= CENTRE_Y;
            vx_pos_q  <= 1'b1;
            vy_pos_q  <= 1'b1;
            score_l_q <= '0;
            score_r_q <= '0;
            goal_q    <= 1'b0;
            hold_q    <= '0;
        end else begin
            x_q       <= x_d;
            y_q       <= y_d;
            vx_pos_q  <= vx_pos_d;
            vy_pos_q  <= vy_pos_d;
            score_l_q <= score_l_d;
            score_r_q <= score_r_d;
            goal_q    <= goal_d;
            hold_q    <= hold_d;
        end
    end

    // Next-state and next-datapath logic.
    always_comb begin
        state_d   = state_q;
        x_d       = x_q;
        y_d       = y_q;
        vx_pos_d  = vx_pos_q;
        vy_pos_d  = vy_pos_q;
        score_l_d = score_l_q;
        score_r_d = score_r_q;
        goal_d    = 1'b0;
        hold_d    = hold_q;
        case (state_q)
            ST_IDLE: begin
                if (serve) state_d = ST_MOVE;
            end
            ST_MOVE: begin
                if (frame_tick) begin
                    if (ny <= 0) begin
                        y_d      = '0;
                        vy_pos_d = 1'b1;
                    end else if (ny >= MAX_Y) begin
                        y_d      = MAX_Y_P;
                        vy_pos_d = 1'b0;
                    end else begin
                        y_d = ny[9:0];
                    end
                    if (left_hit) begin
                        x_d      = L_REST_X;
                        vx_pos_d = 1'b1;
                    end else if (right_hit) begin
                        x_d      = R_REST_X;
                        vx_pos_d = 1'b0;
                    end else if (nx <= 0) begin
                        // Left wall reached: right player scores, next serve
                        // heads back towards the left (conceding) player.
                        x_d       = '0;
                        score_r_d = sat_inc(score_r_q, WIN);
                        goal_d    = 1'b1;
                        vx_pos_d  = 1'b0;
                        state_d   = ST_HOLD;
                    end else if (nx >= MAX_X) begin
                        x_d       = MAX_X_P;
                        score_l_d = sat_inc(score_l_q, WIN);
                        goal_d    = 1'b1;
                        vx_pos_d  = 1'b1;
                        state_d   = ST_HOLD;
                    end else begin
                        x_d = nx[9:0];
                    end
                end
            end
            ST_HOLD: begin
                if (frame_tick) begin
                    if (hold_q == HOLD_LAST) begin
                        hold_d  = '0;
                        x_d     = CENTRE_X;
                        y_d     = CENTRE_Y;
                        state_d = (score_l_q == WIN || score_r_q == WIN) ? ST_OVER : ST_IDLE;
                    end else begin
                        hold_d = hold_q + HOLD_W'(1);
                    end
                end
            end
            ST_OVER: begin
                if (serve) begin
                    score_l_d = '0;
                    score_r_d = '0;
                    x_d       = CENTRE_X;
                    y_d       = CENTRE_Y;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs straight from registers.
    always_comb begin
        puck_x  = x_q;
        puck_y  = y_q;
        score_l = score_l_q;
        score_r = score_r_q;
        goal    = goal_q;
        state   = state_q;
    end

endmodule

// File: tb/tb_puck_motion.sv
module tb_puck_motion;

    localparam int W = 640, H = 480, PS = 8, PH = 64, PW = 8, XL = 16, XR = 616;
    localparam int SPD = 2, WIN = 7, HOLDF = 60, CX = 316, CY = 236;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       frame_tick = 1'b0;
    logic       serve = 1'b0;
    logic [9:0] pad_l_y = 10'd900;
    logic [9:0] pad_r_y = 10'd900;
    logic [9:0] puck_x, puck_y;
    logic [3:0] score_l, score_r;
    logic       goal;
    logic [1:0] state;

    puck_motion dut (
        .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .serve(serve),
        .pad_l_y(pad_l_y), .pad_r_y(pad_r_y),
        .puck_x(puck_x), .puck_y(puck_y),
        .score_l(score_l), .score_r(score_r),
        .goal(goal), .state(state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int goal_seen = 0;

    // Reference model: game rules on plain integers.
    int m_x, m_y, m_vx, m_vy, m_sl, m_sr, m_st, m_hold, m_goal;

    task automatic chk(input string name, input logic [31:0] act, input int exp);
        checks++;
        if (act !== 32'(exp)) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_x = CX; m_y = CY; m_vx = SPD; m_vy = SPD;
        m_sl = 0; m_sr = 0; m_st = 0; m_hold = 0; m_goal = 0;
    endtask

    task automatic model_step(input bit ft, input bit sv);
        int nx, ny, oy, pl, pr;
        bit lh, rh;
        m_goal = 0;
        pl = int'(pad_l_y);
        pr = int'(pad_r_y);
        if (m_st == 0) begin
            if (sv) m_st = 1;
        end else if (m_st == 1) begin
            if (ft) begin
                oy = m_y;
                nx = m_x + m_vx;
                ny = m_y + m_vy;
                lh = (m_vx < 0) && (nx <= XL + PW) && (nx + PS > XL) && (oy + PS > pl) && (oy < pl + PH);
                rh = (m_vx > 0) && (nx + PS >= XR) && (nx < XR + PW) && (oy + PS > pr) && (oy < pr + PH);
                if (ny <= 0) begin m_y = 0; m_vy = SPD; end
                else if (ny >= H - PS) begin m_y = H - PS; m_vy = -SPD; end
                else m_y = ny;
                if (lh) begin
                    m_x = XL + PW; m_vx = SPD;
                end else if (rh) begin
                    m_x = XR - PS; m_vx = -SPD;
                end else begin
                    m_x = (nx < 0) ? 0 : ((nx > W - PS) ? W - PS : nx);
                    if (nx <= 0) begin
                        m_sr = (m_sr + 1 > WIN) ? WIN : m_sr + 1;
                        m_goal = 1; m_st = 2; m_vx = -SPD;
                    end else if (nx >= W - PS) begin
                        m_sl = (m_sl + 1 > WIN) ? WIN : m_sl + 1;
                        m_goal = 1; m_st = 2; m_vx = SPD;
                    end
                end
            end
        end else if (m_st == 2) begin
            if (ft) begin
                m_hold++;
                if (m_hold == HOLDF) begin
                    m_hold = 0; m_x = CX; m_y = CY;
                    m_st = (m_sl == WIN || m_sr == WIN) ? 3 : 0;
                end
            end
        end else begin
            if (sv) begin
                m_sl = 0; m_sr = 0; m_x = CX; m_y = CY; m_st = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("puck_x", 32'(puck_x), m_x);
        chk("puck_y", 32'(puck_y), m_y);
        chk("score_l", 32'(score_l), m_sl);
        chk("score_r", 32'(score_r), m_sr);
        chk("goal", 32'(goal), m_goal);
        chk("state", 32'(state), m_st);
        if (goal === 1'b1) goal_seen++;
    endtask

    // One clock: drive, let the edge happen, advance the model, compare.
    task automatic cyc(input bit ft, input bit sv);
        frame_tick = ft;
        serve = sv;
        @(posedge clk);
        if (!rst_n) model_reset();
        else model_step(ft, sv);
        #1;
        compare_all();
        frame_tick = 1'b0;
        serve = 1'b0;
    endtask

    task automatic frame();
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        repeat (3) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic run_to_goal(input int limit, output int n);
        bit found;
        found = 0;
        n = 0;
        while (!found && n < limit) begin
            cyc(1'b1, 1'b0);
            n++;
            if (goal === 1'b1) found = 1;
            cyc(1'b0, 1'b0);
        end
        chk("goal_reached", 32'(found), 1);
    endtask

    typedef struct {
        int frames;
        int pl;
        int pr;
        int ex;
        int ey;
        int est;
        int esl;
        int esr;
    } vec_t;

    vec_t tbl[11];

    initial begin
        int n;
        int v;
        bit ft, sv;

        // Cumulative path from a serve at centre moving (+2,+2).
        tbl[0]  = '{10,  900, 400, 336, 256, 1, 0, 0};
        tbl[1]  = '{108, 900, 400, 552, 472, 1, 0, 0};
        tbl[2]  = '{1,   900, 400, 554, 470, 1, 0, 0};
        tbl[3]  = '{27,  900, 400, 608, 416, 1, 0, 0};
        tbl[4]  = '{1,   900, 400, 606, 414, 1, 0, 0};
        tbl[5]  = '{206, 900, 400, 194, 2,   1, 0, 0};
        tbl[6]  = '{1,   900, 400, 192, 0,   1, 0, 0};
        tbl[7]  = '{1,   900, 400, 190, 2,   1, 0, 0};
        tbl[8]  = '{82,  900, 400, 26,  166, 1, 0, 0};
        tbl[9]  = '{1,   156, 400, 24,  168, 1, 0, 0};
        tbl[10] = '{1,   156, 400, 26,  170, 1, 0, 0};

        // Reset state.
        do_reset();
        chk("rst_x", 32'(puck_x), CX);
        chk("rst_y", 32'(puck_y), CY);
        chk("rst_state", 32'(state), 0);
        chk("rst_scores", 32'({score_l, score_r}), 0);
        chk("rst_goal", 32'(goal), 0);

        // Serve coincident with frame_tick: transition, no motion.
        cyc(1'b1, 1'b1);
        chk("serve_tick_state", 32'(state), 1);
        chk("serve_tick_x", 32'(puck_x), CX);
        chk("serve_tick_y", 32'(puck_y), CY);

        goal_seen = 0;
        for (int i = 0; i < 11; i++) begin
            pad_l_y = 10'(tbl[i].pl);
            pad_r_y = 10'(tbl[i].pr);
            repeat (tbl[i].frames) frame();
            chk($sformatf("tbl%0d_x", i), 32'(puck_x), tbl[i].ex);
            chk($sformatf("tbl%0d_y", i), 32'(puck_y), tbl[i].ey);
            chk($sformatf("tbl%0d_state", i), 32'(state), tbl[i].est);
            chk($sformatf("tbl%0d_sl", i), 32'(score_l), tbl[i].esl);
            chk($sformatf("tbl%0d_sr", i), 32'(score_r), tbl[i].esr);
        end
        chk("tbl_no_goal", 32'(goal_seen), 0);

        // Left-side goal after one right-paddle return.
        do_reset();
        pad_l_y = 10'd900;
        pad_r_y = 10'd400;
        goal_seen = 0;
        cyc(1'b0, 1'b1);
        run_to_goal(600, n);
        chk("goal_frame", 32'(n), 450);
        chk("goal_sr", 32'(score_r), 1);
        chk("goal_sl", 32'(score_l), 0);
        chk("goal_state", 32'(state), 2);
        chk("goal_x", 32'(puck_x), 0);
        repeat (59) frame();
        chk("hold_59_state", 32'(state), 2);
        frame();
        chk("hold_end_state", 32'(state), 0);
        chk("hold_end_x", 32'(puck_x), CX);
        chk("hold_end_y", 32'(puck_y), CY);
        chk("goal_pulses", 32'(goal_seen), 1);
        cyc(1'b0, 1'b1);
        frame();
        chk("serve_dir_x", 32'(puck_x), CX - SPD);

        // Remaining six right-side goals to game over.
        for (int r = 2; r <= 7; r++) begin
            run_to_goal(600, n);
            repeat (HOLDF) frame();
            if (r < 7) cyc(1'b0, 1'b1);
        end
        chk("over_state", 32'(state), 3);
        chk("over_sr", 32'(score_r), 7);
        repeat (3) frame();
        chk("over_frozen_sr", 32'(score_r), 7);
        cyc(1'b0, 1'b1);
        chk("over_serve_scores", 32'({score_l, score_r}), 0);
        chk("over_serve_state", 32'(state), 0);
        chk("over_serve_x", 32'(puck_x), CX);

        // Asynchronous reset mid-MOVE, observed before any clock edge.
        cyc(1'b0, 1'b1);
        repeat (5) frame();
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_x", 32'(puck_x), CX);
        chk("async_y", 32'(puck_y), CY);
        chk("async_state", 32'(state), 0);
        chk("async_scores", 32'({score_l, score_r}), 0);
        chk("async_goal", 32'(goal), 0);
        model_reset();
        repeat (3) cyc(1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1);
        frame();
        chk("post_rst_x", 32'(puck_x), CX + SPD);
        chk("post_rst_y", 32'(puck_y), CY + SPD);

        // Randomised play against the model, paddles often near the puck.
        do_reset();
        for (int k = 0; k < 20000; k++) begin
            ft = ($urandom_range(0, 2) == 0);
            sv = ($urandom_range(0, 15) == 0);
            if (ft) begin
                if ($urandom_range(0, 1) == 1) v = m_y - int'($urandom_range(0, 70));
                else v = int'($urandom_range(0, 1023));
                if (v < 0) v = 0;
                pad_l_y = 10'(v);
                if ($urandom_range(0, 1) == 1) v = m_y - int'($urandom_range(0, 70));
                else v = int'($urandom_range(0, 1023));
                if (v < 0) v = 0;
                pad_r_y = 10'(v);
            end
            cyc(ft, sv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
